// File: rtl/seg_reg_pkg.sv
// seg_reg_pkg: shared types and default widths for the pipeline segment
// register (pipe_seg_reg) and its per-lane storage element (seg_lane_reg).
package seg_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } seg_state_t;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_LANES       = 1;
   localparam int DEF_STALL_CNT_W = 16;

endpackage

// File: rtl/seg_lane_reg.sv
// seg_lane_reg: one DATA_W-bit lane of storage with hold / load / flush.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, loads FLUSH_VAL
//   load  - capture d on the next edge
//   flush - load FLUSH_VAL on the next edge (wins over load)
//   d     - lane input
//   q     - registered lane value
module seg_lane_reg
   import seg_reg_pkg::*;
#(
   parameter int                 DATA_W    = DEF_DATA_W,
   parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= FLUSH_VAL;
      else if (flush)
         q <= FLUSH_VAL;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipe_seg_reg.sv
// pipe_seg_reg: pipeline segment register with a one-entry skid buffer and
// hazard-unit bubble (hold) / flush controls. Outputs are fully registered.
// Optional feature: define PIPE_SEG_REG_PERF_EN to add the stall_cnt output.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   bubbleE, flushE   - hazard-unit hold (priority) and flush
//   in_valid/in_data/in_ready    - upstream handshake, lane 0 in LSBs
//   out_valid/out_data/out_ready - downstream handshake
//   stall_cnt         - saturating count of stalled cycles (PERF_EN only)
//
// state | meaning
// EMPTY | no live entry
// FULL  | main holds a live entry, skid empty
// SKID  | main and skid both hold live entries, upstream blocked
module pipe_seg_reg
   import seg_reg_pkg::*;
#(
   parameter int                 DATA_W      = DEF_DATA_W,
   parameter int                 LANES       = DEF_LANES,
   parameter logic [DATA_W-1:0]  FLUSH_VAL   = '0,
   parameter int                 STALL_CNT_W = DEF_STALL_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bubbleE,
   input  logic                    flushE,
   input  logic                    in_valid,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [LANES*DATA_W-1:0] out_data,
   input  logic                    out_ready
`ifdef PIPE_SEG_REG_PERF_EN
   ,
   output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

   seg_state_t              state_q, state_d;
   logic                    accept, emit, flush_eff;
   logic                    load_main, load_skid, main_from_skid;
   logic [LANES*DATA_W-1:0] main_q, skid_q, main_d;

   assign in_ready  = ~bubbleE & ~flushE & (state_q != SKID);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready & ~bubbleE;
   // bubbleE masks flushE entirely
   assign flush_eff = flushE & ~bubbleE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush_eff) begin
         state_d = EMPTY;
      end else if (!bubbleE) begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d   = FULL;
                  load_main = 1'b1;
               end
            end
            FULL: begin
               if (accept && !emit) begin
                  state_d   = SKID;
                  load_skid = 1'b1;
               end else if (emit && !accept) begin
                  state_d = EMPTY;
               end else if (emit && accept) begin
                  load_main = 1'b1;
               end
            end
            SKID: begin
               // in_ready is low here, so only a drain can happen
               if (emit) begin
                  state_d        = FULL;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      seg_lane_reg #(
         .DATA_W    (DATA_W),
         .FLUSH_VAL (FLUSH_VAL)
      ) u_main (
         .clk   (clk),
         .rst   (rst),
         .load  (load_main),
         .flush (flush_eff),
         .d     (main_d[l*DATA_W +: DATA_W]),
         .q     (main_q[l*DATA_W +: DATA_W])
      );

      seg_lane_reg #(
         .DATA_W    (DATA_W),
         .FLUSH_VAL (FLUSH_VAL)
      ) u_skid (
         .clk   (clk),
         .rst   (rst),
         .load  (load_skid),
         .flush (flush_eff),
         .d     (in_data[l*DATA_W +: DATA_W]),
         .q     (skid_q[l*DATA_W +: DATA_W])
      );
   end

`ifdef PIPE_SEG_REG_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (flush_eff)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && !bubbleE && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_pipe_seg_reg.sv
// tb_pipe_seg_reg: directed bench for pipe_seg_reg with LANES=2,
// FLUSH_VAL=32'hDEAD_BEEF. Accepted entries are queued as they enter and
// popped and compared as the DUT emits them.
module tb_pipe_seg_reg;

   localparam int          DW    = 32;
   localparam int          LN    = 2;
   localparam logic [31:0] FV    = 32'hDEAD_BEEF;
   localparam logic [63:0] FV2   = {FV, FV};

   logic          clk = 1'b0;
   logic          rst, bubbleE, flushE, in_valid, out_ready;
   logic [63:0]   in_data;
   logic          in_ready, out_valid;
   logic [63:0]   out_data;
`ifdef PIPE_SEG_REG_PERF_EN
   logic [3:0]    stall_cnt;
`endif

   int            checks   = 0;
   int            failures = 0;
   logic [63:0]   sb_q[$];

   always #5 clk = ~clk;

   pipe_seg_reg #(
      .DATA_W      (DW),
      .LANES       (LN),
      .FLUSH_VAL   (FV),
      .STALL_CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bubbleE   (bubbleE),
      .flushE    (flushE),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef PIPE_SEG_REG_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Settle, score the handshake that the coming edge will perform, advance.
   task automatic cyc();
      logic acc, em;
      #1;
      acc = in_valid & in_ready;
      em  = out_valid & out_ready & ~bubbleE;
      if (em) begin
         if (sb_q.size() == 0)
            chk("sb_unexpected_emit", out_data, 64'hx);
         else
            chk("sb_data", out_data, sb_q.pop_front());
      end
      if (acc)
         sb_q.push_back(in_data);
      if (flushE && !bubbleE)
         sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ent(input logic [31:0] v);
      return {v ^ 32'h5A00_0000, v};
   endfunction

   initial begin
      rst = 1'b1; bubbleE = 1'b0; flushE = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // reset state
      #3;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, FV2);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // streaming 1..8 at full rate
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = ent(32'(i));
         #1;
         chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
         if (i > 1)
            chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("stream_drained", {63'd0, out_valid}, 64'd0);

      // skid: A accepted, B into skid, C held upstream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ent(32'hA);
      cyc();
      in_data = ent(32'hB);
      #1 chk("skid_b_ready", {63'd0, in_ready}, 64'd1);
      cyc();
      in_data = ent(32'hC);
      #1;
      chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
      chk("skid_main_a", out_data, ent(32'hA));
      cyc();
      chk("skid_hold_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      cyc();
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("skid_drained", {63'd0, out_valid}, 64'd0);

      // flush in SKID: masked by bubble, then effective
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ent(32'hD);
      cyc();
      in_data = ent(32'hE);
      cyc();
      in_valid = 1'b0;
      bubbleE  = 1'b1;
      flushE   = 1'b1;
      cyc();
      bubbleE = 1'b0;
      flushE  = 1'b0;
      #1;
      chk("bflush_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bflush_out_data", out_data, ent(32'hD));
      chk("bflush_in_ready", {63'd0, in_ready}, 64'd0);
      flushE = 1'b1;
      cyc();
      flushE = 1'b0;
      #1;
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_out_data", out_data, FV2);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("flush_no_stale", {63'd0, out_valid}, 64'd0);
      end

      // bubble holds a live entry even with out_ready high
      in_valid = 1'b1;
      in_data  = ent(32'hF);
      cyc();
      in_valid = 1'b0;
      bubbleE  = 1'b1;
      in_data  = ent(32'h77);
      #1 chk("bubble_in_ready", {63'd0, in_ready}, 64'd0);
      cyc();
      cyc();
      chk("bubble_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bubble_hold_data", out_data, ent(32'hF));
      bubbleE = 1'b0;
      cyc();
      chk("bubble_drained", {63'd0, out_valid}, 64'd0);

      // reset asserted while in SKID
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ent(32'h10);
      cyc();
      in_data = ent(32'h11);
      cyc();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_out_data", out_data, FV2);
      sb_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
      end

`ifdef PIPE_SEG_REG_PERF_EN
      // stall counter saturation and flush clear
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = ent(32'h20);
      cyc();
      in_valid = 1'b0;
      repeat (20) cyc();
      chk("stall_sat", {60'd0, stall_cnt}, 64'hF);
      flushE = 1'b1;
      cyc();
      flushE = 1'b0;
      chk("stall_clear", {60'd0, stall_cnt}, 64'd0);
`endif

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_seg_reg.md
PIPE_SEG_REG -- requirements
Module: pipe_seg_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one lane in bits.
REQ-002 SHALL have parameter LANES, default 1, number of parallel lanes carried per entry.
REQ-003 SHALL have parameter FLUSH_VAL, default 0, DATA_W-bit value loaded into every lane on flush or reset.
REQ-004 SHALL have parameter STALL_CNT_W, default 16, width of the stall counter.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port bubbleE  input  1  hazard-unit hold; freezes all state.
REQ-008 SHALL have port flushE  input  1  hazard-unit flush; empties the stage.
REQ-009 SHALL have port in_valid  input  1  upstream entry valid.
REQ-010 SHALL have port in_data  input  LANES*DATA_W  upstream entry, lane 0 in LSBs.
REQ-011 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-012 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-013 SHALL have port out_data  output  LANES*DATA_W  registered entry to next stage.
REQ-014 SHALL have port out_ready  input  1  downstream consumes this cycle.

Function
REQ-015 SHALL hold a main register and one skid register, tracked by states EMPTY, FULL, SKID.
REQ-016 SHALL define accept = in_valid & in_ready, and emit = out_valid & out_ready & ~bubbleE.
REQ-017 SHALL drive in_ready = ~bubbleE & ~flushE & (state != SKID), combinationally.
REQ-018 SHALL drive out_valid = (state != EMPTY) and out_data directly from the main register, with no combinational path from inputs.
REQ-019 SHALL transition EMPTY->FULL on accept, loading in_data into main.
REQ-020 In FULL, SHALL: on accept & ~emit go to SKID and load in_data into skid; on emit & ~accept go to EMPTY; on both, stay FULL and load in_data into main.
REQ-021 In SKID, SHALL on emit go to FULL and move skid into main; in_ready is 0.
REQ-022 SHALL give bubbleE priority over flushE: while bubbleE=1, state, main, skid and counter hold, and flushE is ignored.
REQ-023 On flushE=1 & bubbleE=0, SHALL go to EMPTY next cycle, load main and skid with FLUSH_VAL in every lane, and drop any in_data.
REQ-024 SHALL give latency of 1 cycle from accept in EMPTY to out_valid=1, and sustain 1 entry per cycle when out_ready=1 continuously.
REQ-025 SHALL never drop or duplicate an accepted entry, and SHALL preserve entry order, absent flush.

Reset
REQ-026 On rst=1, SHALL asynchronously set state=EMPTY, main=skid=FLUSH_VAL in every lane, and counter=0, giving out_valid=0 and out_data=FLUSH_VAL replicated.
REQ-027 SHALL discard any entry in flight when rst asserts mid-operation; in_ready SHALL read 1 in the first cycle after rst deasserts, provided bubbleE=0 and flushE=0.

Configuration
REQ-028 With macro PIPE_SEG_REG_PERF_EN defined, SHALL add output stall_cnt [STALL_CNT_W-1:0], which increments on every cycle with out_valid & ~out_ready & ~bubbleE, saturates at all-ones, and clears on rst or flush.
REQ-029 Without PIPE_SEG_REG_PERF_EN, SHALL have no stall_cnt port and no counter logic.

Structure
REQ-030 SHALL take the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2) and the default widths from shared package seg_reg_pkg.
REQ-031 SHALL implement the per-entry storage as one sub-module, seg_lane_reg (DATA_W-bit, hold/load/flush), instantiated LANES times per register.

Verification
REQ-032 Reset with LANES=2, FLUSH_VAL=32'hDEAD_BEEF -> out_valid=0, out_data=64'hDEADBEEF_DEADBEEF, in_ready=1 after release.
REQ-033 Stream 0x1..0x8 with out_ready=1 -> out_data shows 0x1..0x8 on consecutive cycles, each one cycle after accept.
REQ-034 Accept 0xA, hold out_ready=0, offer 0xB then 0xC -> state SKID, in_ready=0, 0xC is held upstream; raise out_ready -> 0xA, 0xB, 0xC emitted in order.
REQ-035 In SKID, pulse flushE with bubbleE=0 -> next cycle out_valid=0, out_data=FLUSH_VAL; the same pulse with bubbleE=1 -> no change.
REQ-036 Assert rst mid-stream during SKID -> immediate out_valid=0, and no stale entry appears afterwards.
REQ-037 With PIPE_SEG_REG_PERF_EN and STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=4'hF; a flush then clears it to 0.
